// File: rtl/pers_dispatch_ctrl_if.sv
// Dispatch-side bus between the personality dispatch pins and pers_dispatch_ctrl.
// master = dispatcher, slave = controller.
interface pers_dispatch_ctrl_if;
  logic        disp_inst_vld;
  logic [4:0]  disp_inst;
  logic [17:0] disp_aeg_idx;
  logic        disp_aeg_rd;
  logic        disp_aeg_wr;
  logic [63:0] disp_aeg_wr_data;
  logic [17:0] disp_aeg_cnt;
  logic [15:0] disp_exception;
  logic        disp_idle;
  logic        disp_stall;
  logic        disp_rtn_data_vld;
  logic [63:0] disp_rtn_data;

  modport master (
    output disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr, disp_aeg_wr_data,
    input  disp_aeg_cnt, disp_exception, disp_idle, disp_stall, disp_rtn_data_vld, disp_rtn_data
  );

  modport slave (
    input  disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr, disp_aeg_wr_data,
    output disp_aeg_cnt, disp_exception, disp_idle, disp_stall, disp_rtn_data_vld, disp_rtn_data
  );
endinterface

// File: rtl/pers_dispatch_ctrl.sv
// Dispatch controller: AEG register file, PE launch and completion tracking.
// Optional PERS_CYCLE_COUNT_EN turns the last AEG into a read-only RUN-cycle counter.
module pers_dispatch_ctrl #(
  parameter int unsigned NUM_AEG    = 16,
  parameter int unsigned NUM_PE     = 4,
  parameter logic [4:0]  START_INST = 5'd0
) (
  input  logic                    clk,
  input  logic                    i_reset,
  pers_dispatch_ctrl_if.slave     disp,
  output logic [NUM_PE-1:0]       pe_start,
  input  logic [NUM_PE-1:0]       pe_done,
  input  logic                    pe_wr_vld,
  input  logic [17:0]             pe_wr_idx,
  input  logic [63:0]             pe_wr_data,
  output logic                    pe_wr_rdy,
  output logic [NUM_AEG*64-1:0]   aeg_q
);

  localparam int unsigned IW      = (NUM_AEG > 1) ? $clog2(NUM_AEG) : 1;
  localparam int unsigned CNT_IDX = NUM_AEG - 1;

  typedef enum logic [1:0] {IDLE, START, RUN} state_e;

  state_e             state_q, state_d;
  logic [63:0]        aeg_mem_q [NUM_AEG];
  logic [63:0]        aeg_mem_d [NUM_AEG];
  logic [NUM_PE-1:0]  coll_q, coll_d;
  logic [NUM_PE-1:0]  pe_start_q, pe_start_d;
  logic               rtn_vld_q, rtn_vld_d;
  logic [63:0]        rtn_data_q, rtn_data_d;
  logic [15:0]        exc_q, exc_d;

  logic               disp_in_rng, pe_in_rng, disp_wr_ok, pe_wr_ok;
  logic [IW-1:0]      disp_sel, pe_sel;
  logic [NUM_PE-1:0]  mask;

  assign disp_in_rng = 32'(disp.disp_aeg_idx) < NUM_AEG;
  assign pe_in_rng   = 32'(pe_wr_idx) < NUM_AEG;
  assign disp_sel    = disp.disp_aeg_idx[IW-1:0];
  assign pe_sel      = pe_wr_idx[IW-1:0];
  assign mask        = aeg_mem_q[0][NUM_PE-1:0];
  assign pe_wr_rdy   = !disp.disp_aeg_wr;

`ifdef PERS_CYCLE_COUNT_EN
  assign disp_wr_ok = disp_in_rng && (32'(disp.disp_aeg_idx) != CNT_IDX);
  assign pe_wr_ok   = pe_in_rng && (32'(pe_wr_idx) != CNT_IDX);
`else
  assign disp_wr_ok = disp_in_rng;
  assign pe_wr_ok   = pe_in_rng;
`endif

  always_comb begin
    aeg_mem_d = aeg_mem_q;
    // Dispatch write has priority; the engine is only acknowledged when it is absent.
    if (disp.disp_aeg_wr) begin
      if (disp_wr_ok) aeg_mem_d[disp_sel] = disp.disp_aeg_wr_data;
    end else if (pe_wr_vld && pe_wr_ok) begin
      aeg_mem_d[pe_sel] = pe_wr_data;
    end
`ifdef PERS_CYCLE_COUNT_EN
    if (state_q == START)    aeg_mem_d[CNT_IDX] = '0;
    else if (state_q == RUN) aeg_mem_d[CNT_IDX] = aeg_mem_q[CNT_IDX] + 64'd1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    coll_d     = coll_q;
    pe_start_d = '0;
    exc_d      = '0;
    rtn_vld_d  = disp.disp_aeg_rd;
    rtn_data_d = (disp.disp_aeg_rd && disp_in_rng) ? aeg_mem_q[disp_sel] : '0;
    exc_d[1]   = (disp.disp_aeg_rd || disp.disp_aeg_wr) && !disp_in_rng;
    unique case (state_q)
      IDLE: begin
        if (disp.disp_inst_vld) begin
          if (disp.disp_inst == START_INST) begin
            state_d    = START;
            pe_start_d = mask;
          end else begin
            exc_d[0] = 1'b1;
          end
        end
      end
      START: begin
        coll_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        coll_d = coll_q | pe_done;
        if (((coll_q | pe_done) & mask) == mask) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      aeg_mem_q  <= '{default: '0};
      coll_q     <= '0;
      pe_start_q <= '0;
      rtn_vld_q  <= 1'b0;
      rtn_data_q <= '0;
      exc_q      <= '0;
    end else begin
      state_q    <= state_d;
      aeg_mem_q  <= aeg_mem_d;
      coll_q     <= coll_d;
      pe_start_q <= pe_start_d;
      rtn_vld_q  <= rtn_vld_d;
      rtn_data_q <= rtn_data_d;
      exc_q      <= exc_d;
    end
  end

  always_comb begin
    aeg_q = '0;
    for (int unsigned i = 0; i < NUM_AEG; i++) aeg_q[64*i +: 64] = aeg_mem_q[i];
  end

  assign pe_start               = pe_start_q;
  assign disp.disp_aeg_cnt       = 18'(NUM_AEG);
  assign disp.disp_exception     = exc_q;
  assign disp.disp_idle          = (state_q == IDLE);
  assign disp.disp_stall         = (state_q != IDLE);
  assign disp.disp_rtn_data_vld  = rtn_vld_q;
  assign disp.disp_rtn_data      = rtn_data_q;

endmodule

// File: tb/tb_pers_dispatch_ctrl.sv
// Directed self-checking bench for pers_dispatch_ctrl (NUM_AEG=16, NUM_PE=4, START_INST=0).
// Define PERS_CYCLE_COUNT_EN for both files to exercise the RUN-cycle counter.
module tb_pers_dispatch_ctrl;
  logic          clk = 1'b0;
  logic          i_reset;
  logic [3:0]    pe_start;
  logic [3:0]    pe_done;
  logic          pe_wr_vld;
  logic [17:0]   pe_wr_idx;
  logic [63:0]   pe_wr_data;
  logic          pe_wr_rdy;
  logic [1023:0] aeg_q;
  int            errors = 0;
  int            checks = 0;

  pers_dispatch_ctrl_if disp_if ();

  pers_dispatch_ctrl #(.NUM_AEG(16), .NUM_PE(4), .START_INST(5'd0)) dut (
    .clk(clk), .i_reset(i_reset), .disp(disp_if),
    .pe_start(pe_start), .pe_done(pe_done),
    .pe_wr_vld(pe_wr_vld), .pe_wr_idx(pe_wr_idx), .pe_wr_data(pe_wr_data),
    .pe_wr_rdy(pe_wr_rdy), .aeg_q(aeg_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aeg_wr(input logic [17:0] idx, input logic [63:0] data);
    disp_if.disp_aeg_wr = 1'b1; disp_if.disp_aeg_idx = idx; disp_if.disp_aeg_wr_data = data;
    tick();
    disp_if.disp_aeg_wr = 1'b0;
  endtask

  task automatic aeg_rd_chk(input string tag, input logic [17:0] idx, input logic [63:0] exp);
    disp_if.disp_aeg_rd = 1'b1; disp_if.disp_aeg_idx = idx;
    tick();
    disp_if.disp_aeg_rd = 1'b0;
    chk({tag, "_vld"}, 64'(disp_if.disp_rtn_data_vld), 64'd1);
    chk(tag, disp_if.disp_rtn_data, exp);
  endtask

  task automatic inst(input logic [4:0] op);
    disp_if.disp_inst_vld = 1'b1; disp_if.disp_inst = op;
    tick();
    disp_if.disp_inst_vld = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; pe_done = '0; pe_wr_vld = 1'b0; pe_wr_idx = '0; pe_wr_data = '0;
    disp_if.disp_inst_vld = 1'b0; disp_if.disp_inst = '0; disp_if.disp_aeg_idx = '0;
    disp_if.disp_aeg_rd = 1'b0; disp_if.disp_aeg_wr = 1'b0; disp_if.disp_aeg_wr_data = '0;
    tick(); tick();
    i_reset = 1'b0;

    // Reset state
    chk("rst_idle",  64'(disp_if.disp_idle), 64'd1);
    chk("rst_stall", 64'(disp_if.disp_stall), 64'd0);
    chk("rst_rvld",  64'(disp_if.disp_rtn_data_vld), 64'd0);
    chk("rst_rdata", disp_if.disp_rtn_data, 64'd0);
    chk("rst_exc",   64'(disp_if.disp_exception), 64'd0);
    chk("rst_start", 64'(pe_start), 64'd0);
    chk("rst_rdy",   64'(pe_wr_rdy), 64'd1);
    chk("rst_cnt",   64'(disp_if.disp_aeg_cnt), 64'd16);
    chk("rst_aeg",   64'(|aeg_q), 64'd0);

    // AEG write/read, out-of-range read, read-before-write
    aeg_wr(18'd3, 64'hDEADBEEF);
    chk("wr3_aeg", aeg_q[3*64 +: 64], 64'hDEADBEEF);
    aeg_rd_chk("rd3", 18'd3, 64'hDEADBEEF);
    chk("rd3_exc", 64'(disp_if.disp_exception), 64'd0);
    tick();
    chk("rvld_pulse", 64'(disp_if.disp_rtn_data_vld), 64'd0);
    aeg_rd_chk("rd16", 18'd16, 64'd0);
    chk("rd16_exc", 64'(disp_if.disp_exception), 64'h2);
    tick();
    chk("rd16_exc_clr", 64'(disp_if.disp_exception), 64'd0);
    aeg_wr(18'd20, 64'h1);
    chk("wr20_exc", 64'(disp_if.disp_exception), 64'h2);
    disp_if.disp_aeg_rd = 1'b1;
    aeg_wr(18'd3, 64'h55);
    disp_if.disp_aeg_rd = 1'b0;
    chk("rdwr_old", disp_if.disp_rtn_data, 64'hDEADBEEF);
    aeg_rd_chk("rdwr_new", 18'd3, 64'h55);

    // Full mask launch, staggered completion
    aeg_wr(18'd0, 64'hF);
    inst(5'd0);
    chk("s_pe_start", 64'(pe_start), 64'hF);
    chk("s_stall", 64'(disp_if.disp_stall), 64'd1);
    tick();
    chk("s_start_clr", 64'(pe_start), 64'd0);
    inst(5'd7);
    chk("stall_noexc", 64'(disp_if.disp_exception), 64'd0);
    pe_done = 4'h1; tick(); pe_done = '0;
    chk("d1_stall", 64'(disp_if.disp_stall), 64'd1);
    pe_done = 4'h4; tick(); pe_done = '0;
    chk("d4_stall", 64'(disp_if.disp_stall), 64'd1);
    pe_done = 4'hA; tick(); pe_done = '0;
    chk("dA_idle", 64'(disp_if.disp_idle), 64'd1);

    // Done in START cycle is ignored
    aeg_wr(18'd0, 64'h5);
    inst(5'd0);
    chk("m5_start", 64'(pe_start), 64'h5);
    pe_done = 4'h5; tick(); pe_done = '0;
    chk("m5_ign_start", 64'(disp_if.disp_stall), 64'd1);
    pe_done = 4'h5; tick(); pe_done = '0;
    chk("m5_idle", 64'(disp_if.disp_idle), 64'd1);

    // Unimplemented opcode, zero-mask start
    inst(5'd7);
    chk("op7_exc", 64'(disp_if.disp_exception), 64'h1);
    chk("op7_idle", 64'(disp_if.disp_idle), 64'd1);
    aeg_wr(18'd0, 64'h0);
    inst(5'd0);
    chk("m0_start", 64'(pe_start), 64'd0);
    chk("m0_stall1", 64'(disp_if.disp_stall), 64'd1);
    tick();
    chk("m0_stall2", 64'(disp_if.disp_stall), 64'd1);
    tick();
    chk("m0_idle", 64'(disp_if.disp_idle), 64'd1);

    // Engine write collides with dispatch write
    pe_wr_vld = 1'b1; pe_wr_idx = 18'd5; pe_wr_data = 64'hAAAA;
    disp_if.disp_aeg_wr = 1'b1; disp_if.disp_aeg_idx = 18'd6; disp_if.disp_aeg_wr_data = 64'hBBBB;
    #1;
    chk("rdy_blocked", 64'(pe_wr_rdy), 64'd0);
    tick();
    disp_if.disp_aeg_wr = 1'b0;
    #1;
    chk("rdy_free", 64'(pe_wr_rdy), 64'd1);
    chk("pe5_not_yet", aeg_q[5*64 +: 64], 64'd0);
    tick();
    pe_wr_idx = 18'd40; pe_wr_data = 64'hCCCC;
    tick();
    pe_wr_vld = 1'b0;
    chk("pe_oor_noexc", 64'(disp_if.disp_exception), 64'd0);
    aeg_rd_chk("rd5", 18'd5, 64'hAAAA);
    aeg_rd_chk("rd6", 18'd6, 64'hBBBB);

    // Reset mid-RUN
    aeg_wr(18'd0, 64'h3);
    inst(5'd0);
    tick();
    i_reset = 1'b1; pe_done = 4'h3;
    tick();
    i_reset = 1'b0; pe_done = '0;
    chk("rrun_idle", 64'(disp_if.disp_idle), 64'd1);
    chk("rrun_aeg", 64'(|aeg_q), 64'd0);

`ifdef PERS_CYCLE_COUNT_EN
    aeg_wr(18'd0, 64'h1);
    inst(5'd0);
    tick();
    for (int i = 0; i < 10; i++) tick();
    pe_done = 4'h1; tick(); pe_done = '0;
    chk("cc_idle", 64'(disp_if.disp_idle), 64'd1);
    aeg_rd_chk("cc_rd", 18'd15, 64'd11);
    aeg_wr(18'd15, 64'h123);
    chk("cc_wr_noexc", 64'(disp_if.disp_exception), 64'd0);
    aeg_rd_chk("cc_rd_ro", 18'd15, 64'd11);
`else
    aeg_wr(18'd15, 64'h123);
    aeg_rd_chk("rd15", 18'd15, 64'h123);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
